// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, LSB first,
// one bit per clock, with registered sum/cout and a one-cycle done pulse.

// Single-bit full adder shared by the sequencer.
module fulladd (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);
  assign s_out = a_in ^ b_in ^ c_in;
  assign c_out = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

// state | meaning
// IDLE  | waiting for start; operands not latched
// RUN   | one operand bit per edge through the full adder, LSB first
// DONE  | sum/cout hold a fresh result; done pulses for this one cycle
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_shift;

  fulladd u_fa (
    .a_in  (a_sh_q[0]),
    .b_in  (b_sh_q[0]),
    .c_in  (carry_q),
    .s_out (fa_s),
    .c_out (fa_c)
  );

  // New sum bit enters at the MSB; written as shift-then-insert so WIDTH=1 needs no special slice.
  always_comb begin
    s_shift            = s_sh_q >> 1;
    s_shift[WIDTH-1]   = fa_s;
  end

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sh_d  = s_shift;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_shift;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: three instances (WIDTH 1, 8, 16) sharing clock and reset.
module tb_serial_add_ctrl;
  localparam int NI = 3;
  localparam int WD [NI] = '{1, 8, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_v [NI];
  logic [31:0] a_v     [NI];
  logic [31:0] b_v     [NI];
  logic        cin_v   [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        cout_v  [NI];
  logic [31:0] sum_v   [NI];

  logic        busy1, done1, cout1;
  logic [0:0]  sum1;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  serial_add_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]),
    .cin(cin_v[0]), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_add_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .cin(cin_v[1]), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_add_ctrl #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][15:0]), .b(b_v[2][15:0]),
    .cin(cin_v[2]), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

  always_comb begin
    busy_v[0] = busy1;  done_v[0] = done1;  cout_v[0] = cout1;  sum_v[0] = {31'd0, sum1};
    busy_v[1] = busy8;  done_v[1] = done8;  cout_v[1] = cout8;  sum_v[1] = {24'd0, sum8};
    busy_v[2] = busy16; done_v[2] = done16; cout_v[2] = cout16; sum_v[2] = {16'd0, sum16};
  end

  int checks = 0;
  int errors = 0;
  int ndone [NI];
  logic prev_done [NI];
  logic [32:0] sb [NI][$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    logic [32:0] t;
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    t = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
    return {t[w], t[31:0] & m};
  endfunction

  // Scoreboard: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_n && done_v[k]) begin
        ndone[k]++;
        if (prev_done[k]) chk($sformatf("done_width_w%0d", WD[k]), 64'd2, 64'd1);
        if (sb[k].size() == 0) begin
          chk($sformatf("unexpected_done_w%0d", WD[k]), 64'd1, 64'd0);
        end else begin
          chk($sformatf("result_w%0d", WD[k]), {31'd0, cout_v[k], sum_v[k]},
              {31'd0, sb[k].pop_front()});
        end
      end
      prev_done[k] = rst_n && done_v[k];
    end
  end

  // Call at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [32:0] e, input int inject);
    int lat;
    start_v[k] = 1'b1;
    a_v[k] = a;
    b_v[k] = b;
    cin_v[k] = c;
    sb[k].push_back(e);
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    a_v[k] = $urandom;
    b_v[k] = $urandom;
    cin_v[k] = 1'($urandom_range(0, 1));
    chk($sformatf("busy_after_accept_w%0d", WD[k]), {63'd0, busy_v[k]}, 64'd1);
    lat = 0;
    for (int i = 1; i <= WD[k] + 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[k]) begin
        lat = i;
        break;
      end
      start_v[k] = (i == inject);
      if (i == inject) begin
        a_v[k] = 32'h1;
        b_v[k] = 32'h1;
      end
    end
    start_v[k] = 1'b0;
    chk($sformatf("latency_w%0d", WD[k]), 64'(lat), 64'(WD[k]));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int n0;
    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    for (int k = 0; k < NI; k++) begin
      start_v[k] = 1'b1;
      a_v[k] = 32'hFFFF_FFFF;
      b_v[k] = 32'hFFFF_FFFF;
      cin_v[k] = 1'b1;
      ndone[k] = 0;
      prev_done[k] = 1'b0;
    end

    // Reset held 3 clocks with start asserted.
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_busy", {63'd0, busy8}, 64'd0);
      chk("reset_done", {63'd0, done8}, 64'd0);
      chk("reset_sum", {56'd0, sum8}, 64'd0);
      chk("reset_cout", {63'd0, cout8}, 64'd0);
    end
    for (int k = 0; k < NI; k++) start_v[k] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {62'd0, busy16, busy1}, 64'd0);

    // Table vectors on the 8-bit instance, back-to-back.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_op(1, {24'd0, tbl[i].a}, {24'd0, tbl[i].b}, tbl[i].c, {tbl[i].co, 24'd0, tbl[i].s}, 0);
    end

    // Start pulsed mid-RUN must be ignored: one done, original result.
    @(negedge clk);
    n0 = ndone[1];
    run_op(1, 32'h35, 32'h4A, 1'b0, {1'b0, 32'h7F}, 3);
    repeat (12) @(negedge clk);
    chk("busy_reject_ndone", 64'(ndone[1] - n0), 64'd1);
    chk("busy_reject_idle", {63'd0, busy8}, 64'd0);

    // Reset sampled at edge 4 of RUN abandons the operation.
    @(negedge clk);
    n0 = ndone[1];
    start_v[1] = 1'b1;
    a_v[1] = 32'h0F;
    b_v[1] = 32'h01;
    cin_v[1] = 1'b0;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_rst_busy", {63'd0, busy8}, 64'd0);
    chk("midop_rst_done", {63'd0, done8}, 64'd0);
    chk("midop_rst_sum", {55'd0, cout8, sum8}, 64'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midop_rst_no_done", 64'(ndone[1] - n0), 64'd0);
    run_op(1, 32'h0F, 32'h01, 1'b0, {1'b0, 32'h10}, 0);

    // Random back-to-back operands on all three widths.
    fork
      begin
        logic [31:0] ra, rb;
        logic rc;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
          run_op(0, ra, rb, rc, model(1, ra, rb, rc), 0);
        end
      end
      begin
        logic [31:0] ra, rb;
        logic rc;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
          run_op(1, ra, rb, rc, model(8, ra, rb, rc), 0);
        end
      end
      begin
        logic [31:0] ra, rb;
        logic rc;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
          run_op(2, ra, rb, rc, model(16, ra, rb, rc), 0);
        end
      end
    join

    repeat (4) @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk($sformatf("scoreboard_empty_w%0d", WD[k]), 64'(sb[k].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
